stopwatch_sseg_scan: RTL and testbench
======================================

Name: stopwatch_sseg_scan

Overview:
- Display back-end fed by the stopwatch core's six BCD digits d5..d0 (format MM:SS.cc).
- Time-multiplexes the digits onto an 8-anode, active-low seven-segment module.
- Decimal points mark minute and second boundaries.
- Snapshots the digits once per frame so a scan never shows a torn value.
- Adds an optional blanking window against ghosting and optional leading-zero suppression.

Parameters:
- SCAN_DVSR, 100_000, clock cycles per digit slot (1 kHz slot rate at 100 MHz); must be >= 2.
- BLANK_CYC, 1_000, cycles at the start of each slot with all anodes off; must be < SCAN_DVSR; 0 disables blanking.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- d5,d4,d3,d2,d1,d0  in  4 each  BCD digits from the stopwatch core (d5 = tens of minutes, d0 = hundredths).
- lz_en  in  1  when 1, blank d5 if its snapshot is 0.
- an  out  8  anode enables, active-low; an[i] selects display digit i.
- sseg  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset: presc=0, idx=0, snapshot regs=0, an=8'hFF, sseg=8'hFF. All values apply asynchronously on rst rise and hold while rst=1.
- Prescaler presc counts 0..SCAN_DVSR-1 and wraps. slot_end = (presc==SCAN_DVSR-1).
- Digit index idx counts 0..5. It advances on slot_end and wraps 5->0. Values 6 and 7 are never reached; an[7:6] are always 1.
- Snapshot:
  - On slot_end with idx==5, all six snapshot regs load d5..d0 in the same cycle.
  - Digits therefore change only at frame boundaries.
  - The first frame after reset displays zeros.
- Slot output, idx=k, selected digit s=snap[k]:
  - Blanked when presc < BLANK_CYC, or when k==5 && lz_en && s==0. Blanked means an=8'hFF, sseg=8'hFF.
  - Otherwise an = ~(8'b1<<k), sseg = {~dp_k, seg(s)}.
- Decimal points: dp_k=1 for k==2 (SS.cc) and k==4 (M:SS separator); 0 otherwise.
- seg() patterns, active-low g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 = 0111111 (dash, g only), flagging illegal BCD.
- Latency: an/sseg are registered, so they reflect the presc/idx/snapshot state of the previous cycle (1-cycle latency). First digit 0 output appears at cycle BLANK_CYC+1 after reset release.
- lz_en is sampled combinationally each cycle; no snapshot is needed.
- Simultaneous events:
  - slot_end at idx==5 does three things in one edge: wrap idx to 0, reset presc to 0, load the snapshot.
  - The new digit 0 is shown from the next slot start, after blanking.
- Reset mid-scan: the outputs go immediately to all-off. Scan restarts at idx 0 with a zero snapshot.

Decomposition:
- Package stopwatch_pkg holds:
  - typedef bcd_t (logic [3:0]) and typedef sseg_t (logic [7:0]).
  - Constants SSEG_OFF=8'hFF, SSEG_DASH=8'hBF, N_DIGITS=6.
  - Function bcd_to_sseg(bcd_t) returning the 7-bit pattern.
- One sub-module, sseg_decode: purely combinational BCD->segment lookup, instantiated once on the muxed digit.
- Prescaler, index counter, snapshot and output registers stay in the top block.

Test Plan (SCAN_DVSR=4, BLANK_CYC=1 for sim):
1. Reset release with digits 0 and lz_en=0:
   - Slots 0..5 give an = FE, FD, FB, F7, EF, DF.
   - sseg = C0 except slots 2 and 4, which give 40.
   - The first cycle of every slot gives an=FF.
2. Inputs 5,9,5,9,9,9 (d5..d0) applied mid-frame:
   - Outputs stay zero until the end of the idx-5 slot.
   - Next frame: slot0 = sseg 90, slot2 = 10 (9 with dp), slot3 = 92, slot4 = 10, slot5 = 92.
3. lz_en=1, d5=0, d4=3:
   - Slot 5 shows an=FF, sseg=FF for the whole slot.
   - Slot 4 shows an=EF, sseg=30.
   - With d5=1, slot 5 shows an=DF, sseg=F9.
4. Illegal BCD d1=4'hC:
   - Slot 1 shows an=FD, sseg=BF.
5. rst asserted mid-slot 3:
   - an/sseg go to FF the same cycle without a clock edge.
   - After release, the scan restarts at slot 0 showing C0.
6. Slot timing:
   - Each anode is active for exactly SCAN_DVSR-BLANK_CYC=3 consecutive cycles.
   - Frame period is 24 cycles.
   - Verify no cycle has two anodes low.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types, constants and BCD-to-segment table
// for the stopwatch seven-segment display back-end.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [7:0] sseg_t;

  localparam sseg_t SSEG_OFF  = 8'hFF;
  localparam sseg_t SSEG_DASH = 8'hBF;
  localparam int    N_DIGITS  = 6;

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash
  function automatic logic [6:0] bcd_to_sseg(bcd_t v);
    logic [6:0] p;
    case (v)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = SSEG_DASH[6:0];
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sseg_decode.sv
// Combinational BCD digit to active-low
// seven-segment pattern (no decimal point).
module sseg_decode
  import stopwatch_pkg::*;
(
  input  bcd_t       i_bcd,
  output logic [6:0] o_seg
);

  // Pure table lookup on the selected digit
  always_comb begin
    o_seg = bcd_to_sseg(i_bcd);
  end

endmodule

// File: rtl/stopwatch_sseg_scan.sv
// Six-digit MM:SS.cc multiplexed display driver
// with per-frame snapshot, blanking and LZ suppression.
module stopwatch_sseg_scan
  import stopwatch_pkg::*;
#(
  parameter int SCAN_DVSR = 100_000,
  parameter int BLANK_CYC = 1_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d5,
  input  logic [3:0] d4,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic       lz_en,
  output logic [7:0] an,
  output logic [7:0] sseg
);

  localparam int PW = $clog2(SCAN_DVSR);
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DVSR - 1);
  localparam logic [PW-1:0] P_BLNK = PW'(BLANK_CYC);
  localparam logic [2:0]    I_LAST = 3'(N_DIGITS - 1);

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  bcd_t          r_snap [N_DIGITS];
  logic          w_slot_end;
  logic          w_frame_end;
  bcd_t          w_dig;
  logic [6:0]    w_seg;
  logic          w_dp;
  logic          w_blank;

  assign w_slot_end  = (r_presc == P_LAST);
  assign w_frame_end = w_slot_end && (r_idx == I_LAST);

  // Slot prescaler: 0..SCAN_DVSR-1, wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_presc <= '0;
    else if (w_slot_end) r_presc <= '0;
    else                 r_presc <= r_presc + 1'b1;
  end

  // Digit index: 0..5, advances once per slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_idx <= '0;
    else if (w_frame_end) r_idx <= '0;
    else if (w_slot_end)  r_idx <= r_idx + 1'b1;
  end

  // Frame snapshot so one scan never shows a torn time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_DIGITS; i++) r_snap[i] <= '0;
    end else if (w_frame_end) begin
      r_snap[0] <= d0;
      r_snap[1] <= d1;
      r_snap[2] <= d2;
      r_snap[3] <= d3;
      r_snap[4] <= d4;
      r_snap[5] <= d5;
    end
  end

  // Select the digit for the current slot
  always_comb begin
    case (r_idx)
      3'd0:    w_dig = r_snap[0];
      3'd1:    w_dig = r_snap[1];
      3'd2:    w_dig = r_snap[2];
      3'd3:    w_dig = r_snap[3];
      3'd4:    w_dig = r_snap[4];
      3'd5:    w_dig = r_snap[5];
      default: w_dig = '0;
    endcase
  end

  sseg_decode u_dec (
    .i_bcd (w_dig),
    .o_seg (w_seg)
  );

  // Dots after seconds (SS.cc) and after minutes (M:SS)
  always_comb begin
    w_dp    = (r_idx == 3'd2) || (r_idx == 3'd4);
    w_blank = 1'b0;
    if ((BLANK_CYC > 0) && (r_presc < P_BLNK)) w_blank = 1'b1;
    if ((r_idx == I_LAST) && lz_en && (w_dig == 4'd0))
      w_blank = 1'b1;
  end

  // Registered anode/segment drive, all-off while blanked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an   <= SSEG_OFF;
      sseg <= SSEG_OFF;
    end else if (w_blank) begin
      an   <= SSEG_OFF;
      sseg <= SSEG_OFF;
    end else begin
      an   <= ~(8'b1 << r_idx);
      sseg <= {~w_dp, w_seg};
    end
  end

endmodule

// File: tb/tb_stopwatch_sseg_scan.sv
// Self-checking bench: directed phases plus random digits
// against a time-based reference model of the scan.
module tb_stopwatch_sseg_scan;

  localparam int D = 4;
  localparam int B = 1;
  localparam int F = 6 * D;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d [6];
  logic       lz_en = 1'b0;
  logic [7:0] an;
  logic [7:0] sseg;

  int checks = 0;
  int errors = 0;
  int c = 0;
  logic [3:0] msnap [6];
  logic [7:0] e_an;
  logic [7:0] e_sseg;
  int acnt [8];

  stopwatch_sseg_scan #(.SCAN_DVSR(D), .BLANK_CYC(B)) dut (
    .clk   (clk),
    .rst   (rst),
    .d5    (d[5]),
    .d4    (d[4]),
    .d3    (d[3]),
    .d2    (d[2]),
    .d1    (d[1]),
    .d0    (d[0]),
    .lz_en (lz_en),
    .an    (an),
    .sseg  (sseg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] segp(input logic [3:0] v);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000};
    if (v > 4'd9) return 7'b0111111;
    return t[v];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s c=%0d observed %h expected %h",
             tag, c, obs, exp);
    end
  endtask

  // One clock: predict from elapsed-time position, then compare
  task automatic step();
    int p, k;
    logic [3:0] s;
    logic blank;
    p = c % D;
    k = (c / D) % 6;
    s = msnap[k];
    blank = (p < B) || (k == 5 && lz_en && s == 4'd0);
    e_an   = blank ? 8'hFF : ~(8'b1 << k);
    e_sseg = blank ? 8'hFF : {~(k == 2 || k == 4), segp(s)};
    if (c % F == F - 1)
      for (int i = 0; i < 6; i++) msnap[i] = d[i];
    @(posedge clk);
    #1;
    c++;
    chk("an", an, e_an);
    chk("sseg", sseg, e_sseg);
    checks++;
    assert ($countones(~an) <= 1) else begin
      errors++;
      $error("FAIL two_anodes observed %h expected one-cold", an);
    end
    for (int i = 0; i < 8; i++)
      if (an == ~(8'b1 << i)) acnt[i]++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_d(input logic [3:0] a5, input logic [3:0] a4,
                       input logic [3:0] a3, input logic [3:0] a2,
                       input logic [3:0] a1, input logic [3:0] a0);
    d[5] = a5; d[4] = a4; d[3] = a3;
    d[2] = a2; d[1] = a1; d[0] = a0;
  endtask

  task automatic model_reset();
    c = 0;
    for (int i = 0; i < 6; i++) msnap[i] = 4'd0;
  endtask

  initial begin
    set_d(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_an", an, 8'hFF);
    chk("reset_sseg", sseg, 8'hFF);
    @(negedge clk);
    rst = 1'b0;

    // Zeros frame: anode walk, dots on slots 2 and 4
    run(F);

    // New digits mid-frame appear only next frame
    run(10);
    set_d(5, 9, 5, 9, 9, 9);
    run(2 * F);

    // Leading-zero suppression on tens of minutes
    lz_en = 1'b1;
    set_d(0, 3, 5, 9, 9, 9);
    run(2 * F);
    d[5] = 4'd1;
    run(2 * F);

    // Illegal BCD shows a dash
    d[1] = 4'hC;
    run(2 * F);

    // Slot timing over one aligned frame
    while (c % F != 0) step();
    for (int i = 0; i < 8; i++) acnt[i] = 0;
    run(F);
    for (int i = 0; i < 8; i++) begin
      checks++;
      assert (acnt[i] == ((i < 6) ? D - B : 0)) else begin
        errors++;
        $error("FAIL an_count[%0d] observed %0d expected %0d",
               i, acnt[i], (i < 6) ? D - B : 0);
      end
    end

    // Async reset in the middle of slot 3
    while (c % F != 14) step();
    rst = 1'b1;
    #1;
    chk("async_rst_an", an, 8'hFF);
    chk("async_rst_sseg", sseg, 8'hFF);
    @(posedge clk);
    #1;
    chk("hold_rst_an", an, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(F + 6);

    // Random digits and lz_en
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < 6; i++) d[i] = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 0) d[5] = 4'd0;
      end
      if ($urandom_range(0, 15) == 0) lz_en = 1'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
